ser_tx_scheduler: RTL

Round-robin scheduler that shares the 4-bit parallel-load serializer among NREQ requesters. It picks one pending nibble, clears and loads the serializer, and waits for its finish flag. It then acknowledges the winning requester and returns to idle. It sits between the requester logic and the serializer's `reset`/`load`/`data_in`/`fn` pins and owns them exclusively.

---
 rtl/ser_tx_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/ser_tx_scheduler.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ser_tx_pkg.sv
// Shared types and constants for the serializer transmit scheduler.
package ser_tx_pkg;

    localparam int unsigned NIB_W            = 4;
    localparam int unsigned CNT_W            = 8;
    localparam int unsigned SER_SHIFT_CYCLES = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_SHIFT,
        S_DONE,
        S_FAIL
    } ser_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first pending request after index `last`.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic            valid,
    output logic [IW-1:0]   winner
);

    // Scan from farthest to nearest so the nearest pending request wins.
    always_comb begin
        int unsigned idx;
        idx    = 0;
        valid  = |req;
        winner = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = 32'(last) + 32'(k);
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req[IW'(idx)]) begin
                winner = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/ser_tx_scheduler.sv
// Round-robin owner of the shared 4-bit serializer: clear, load, wait for fn, ack.
module ser_tx_scheduler
    import ser_tx_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 15,
    localparam int unsigned IW     = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NIB_W*NREQ-1:0] data,
    output logic [NREQ-1:0]       ack,
    output logic                  err,
    output logic                  busy,
    output logic [IW-1:0]         gnt_id,
    output logic                  ser_clr,
    output logic                  ser_load,
    output logic [NIB_W-1:0]      ser_data,
    input  logic                  ser_fn
);

    ser_state_t       state_q;
    ser_state_t       state_d;
    logic [NIB_W-1:0] hold_q;
    logic [CNT_W-1:0] cnt_q;
    logic             arb_valid;
    logic [IW-1:0]    arb_winner;
    logic [NIB_W-1:0] win_nib;
    logic             cnt_at_limit;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req    (req),
        .last   (gnt_id),
        .valid  (arb_valid),
        .winner (arb_winner)
    );

    always_comb begin
        win_nib = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_winner == IW'(i)) begin
                win_nib = data[NIB_W*i +: NIB_W];
            end
        end
    end

    assign cnt_at_limit = (cnt_q == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus output decode from registered state only.
    always_comb begin
        state_d  = state_q;
        ack      = '0;
        err      = 1'b0;
        busy     = 1'b1;
        ser_clr  = 1'b0;
        ser_load = 1'b0;
        ser_data = '0;
        case (state_q)
            S_IDLE: begin
                busy     = 1'b0;
                ser_load = 1'b1;
                if (arb_valid) begin
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                ser_clr = 1'b1;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                ser_load = 1'b1;
                ser_data = hold_q;
                state_d  = S_SHIFT;
            end
            S_SHIFT: begin
                ser_data = hold_q;
                if (ser_fn) begin
                    state_d = S_DONE;
                end else if (cnt_at_limit) begin
                    state_d = S_FAIL;
                end
            end
            S_DONE: begin
                ack[gnt_id] = 1'b1;
                ser_load    = 1'b1;
                state_d     = S_IDLE;
            end
            S_FAIL: begin
                err     = 1'b1;
                ser_clr = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Grant/nibble latch on the IDLE->CLR edge; saturating wait counter in SHIFT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_id <= IW'(NREQ - 1);
            hold_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (state_q == S_IDLE && arb_valid) begin
                gnt_id <= arb_winner;
                hold_q <= win_nib;
            end
            if (state_q == S_LOAD) begin
                cnt_q <= '0;
            end else if (state_q == S_SHIFT && !cnt_at_limit) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule
